// File: rtl/shiftreg_scheduler_if.sv
// Shared serial shift-register bus bundle.
// Host request/ack side plus the chain-facing serial lines.
interface shiftreg_scheduler_if #(
  parameter int N_CHAINS = 2,
  parameter int WIDTH    = 8
);
  logic [N_CHAINS-1:0]       req;
  logic [N_CHAINS-1:0]       ack;
  logic                      busy;
  logic [N_CHAINS*WIDTH-1:0] data_out;
  logic [N_CHAINS*WIDTH-1:0] data_in;
  logic                      ser_out;
  logic                      ser_in;
  logic                      sclk;
  logic [N_CHAINS-1:0]       load;

  modport master (
    output req, data_out, ser_in,
    input  ack, busy, data_in, ser_out, sclk, load
  );

  modport slave (
    input  req, data_out, ser_in,
    output ack, busy, data_in, ser_out, sclk, load
  );
endinterface

// File: rtl/shiftreg_scheduler.sv
// Round-robin scheduler sharing one 595/165-style serial bus
// among several chains, with optional periodic refresh.
module shiftreg_scheduler #(
  parameter int N_CHAINS      = 2,
  parameter int WIDTH         = 8,
  parameter int DIVIDER       = 100,
  parameter int REFRESH_TICKS = 1000
) (
  input logic             clk,
  input logic             rst_n,
  shiftreg_scheduler_if.slave bus
);
  localparam int TW = $clog2(DIVIDER + 1);
  localparam int IW = (N_CHAINS > 1) ? $clog2(N_CHAINS) : 1;

  typedef enum logic [2:0] {
    IDLE, SETUP, HIGH, LOW, LATCH, DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [TW-1:0]             tcnt_q;
  logic [31:0]               rcnt_q, rcnt_d;
  logic [N_CHAINS-1:0]       pend_q, pend_d;
  logic [IW-1:0]             rr_q, rr_d;
  logic [IW-1:0]             gnt_q, gnt_d;
  logic [WIDTH-1:0]          snap_q, snap_d;
  logic [WIDTH-1:0]          shad_q, shad_d;
  logic [7:0]                bit_q, bit_d;
  logic                      so_q, so_d;
  logic                      sclk_q, sclk_d;
  logic [N_CHAINS-1:0]       load_q, load_d;
  logic [N_CHAINS-1:0]       ack_q, ack_d;
  logic                      busy_q, busy_d;
  logic [N_CHAINS*WIDTH-1:0] din_q, din_d;

  logic          tick;
  logic          rfire;
  logic          found;
  logic [IW-1:0] pick;

  assign tick = (tcnt_q == TW'(DIVIDER - 1));

  // first pending chain after the last grant, wrapping around
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int j = 0; j < N_CHAINS; j++) begin
      for (int k = 0; k < N_CHAINS; k++) begin
        if (!found && pend_q[k] &&
            k == (int'(rr_q) + 1 + j) % N_CHAINS) begin
          pick  = IW'(k);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rfire   = 1'b0;
    pend_d  = pend_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    snap_d  = snap_q;
    shad_d  = shad_q;
    bit_d   = bit_q;
    so_d    = so_q;
    sclk_d  = sclk_q;
    load_d  = load_q;
    ack_d   = '0;
    busy_d  = busy_q;
    din_d   = din_q;

    if (REFRESH_TICKS != 0 && tick) begin
      if (rcnt_q == 32'd1) begin
        rfire  = 1'b1;
        rcnt_d = 32'(REFRESH_TICKS);
      end else begin
        rcnt_d = rcnt_q - 32'd1;
      end
    end

    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            gnt_d  = pick;
            rr_d   = pick;
            bit_d  = '0;
            busy_d = 1'b1;
            for (int k = 0; k < N_CHAINS; k++) begin
              if (IW'(k) == pick) begin
                snap_d    = bus.data_out[k*WIDTH +: WIDTH];
                pend_d[k] = 1'b0;
              end
            end
            state_d = SETUP;
          end
        end
        SETUP: begin
          so_d    = snap_q[WIDTH-1];
          state_d = HIGH;
        end
        HIGH: begin
          sclk_d  = 1'b1;
          shad_d  = (shad_q << 1) | WIDTH'(bus.ser_in);
          state_d = LOW;
        end
        LOW: begin
          sclk_d = 1'b0;
          snap_d = snap_q << 1;
          if (bit_q == 8'(WIDTH - 1)) begin
            state_d = LATCH;
          end else begin
            bit_d   = bit_q + 8'd1;
            state_d = SETUP;
          end
        end
        LATCH: begin
          for (int k = 0; k < N_CHAINS; k++) begin
            if (IW'(k) == gnt_q) load_d[k] = 1'b0;
          end
          state_d = DONE;
        end
        DONE: begin
          load_d = '1;
          so_d   = 1'b0;
          busy_d = 1'b0;
          for (int k = 0; k < N_CHAINS; k++) begin
            if (IW'(k) == gnt_q) begin
              din_d[k*WIDTH +: WIDTH] = shad_q;
              ack_d[k]                = 1'b1;
            end
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // a request arriving on the grant clk survives the clear
    pend_d = pend_d | bus.req | {N_CHAINS{rfire}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      rcnt_q  <= 32'(REFRESH_TICKS);
      pend_q  <= '0;
      rr_q    <= IW'(N_CHAINS - 1);
      gnt_q   <= '0;
      snap_q  <= '0;
      shad_q  <= '0;
      bit_q   <= '0;
      so_q    <= 1'b0;
      sclk_q  <= 1'b0;
      load_q  <= '1;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tick ? '0 : tcnt_q + TW'(1);
      rcnt_q  <= rcnt_d;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      snap_q  <= snap_d;
      shad_q  <= shad_d;
      bit_q   <= bit_d;
      so_q    <= so_d;
      sclk_q  <= sclk_d;
      load_q  <= load_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      din_q   <= din_d;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.busy    = busy_q;
  assign bus.data_in = din_q;
  assign bus.ser_out = so_q;
  assign bus.sclk    = sclk_q;
  assign bus.load    = load_q;
endmodule
